// File: rtl/ulpi_tx_engine.sv
// Link-side ULPI transmit engine: register writes (TX CMD + data) and NOPID chirp
// transmit, with dir-abort retry and a one-cycle completion pulse. All outputs registered.
module ulpi_tx_engine #(
  parameter int          MAX_RETRY = 3,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_stp_o,
  input  logic       phy_write_i,
  input  logic       phy_nopid_i,
  input  logic       phy_stop_i,
  input  logic [7:0] phy_addr_i,
  input  logic [7:0] phy_data_i,
  output logic       phy_done_o,
  output logic       phy_error_o,
  output logic       busy_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD      = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_STOP     = 3'd3;
  localparam logic [2:0] S_NOPID    = 3'd4;
  localparam logic [2:0] S_NSTOP    = 3'd5;
  localparam logic [2:0] S_WAIT_DIR = 3'd6;

  localparam int         RW        = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [7:0] NOPID_CMD = 8'h40;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  logic [2:0]    state;
  req_t          req_q;
  logic [RW-1:0] retry_q;
  logic          ta_q;        // turnaround cycle after dir fell has been spent
  logic          nopid_q;     // WAIT_DIR was entered from NOPID: no retry, no done
  logic          nxt_seen_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req_q       <= '0;
      retry_q     <= '0;
      ta_q        <= 1'b0;
      nopid_q     <= 1'b0;
      nxt_seen_q  <= 1'b0;
      ulpi_data_o <= IDLE_BYTE;
      ulpi_stp_o  <= 1'b0;
      phy_done_o  <= 1'b0;
      phy_error_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      ulpi_data_o <= IDLE_BYTE;
      ulpi_stp_o  <= 1'b0;
      phy_done_o  <= 1'b0;
      phy_error_o <= 1'b0;
      busy_o      <= 1'b1;
      case (state)
        S_IDLE: begin
          busy_o <= 1'b0;
          if (!ulpi_dir && phy_write_i) begin
            req_q       <= '{addr: phy_addr_i, data: phy_data_i};
            nopid_q     <= 1'b0;
            ulpi_data_o <= phy_addr_i;
            busy_o      <= 1'b1;
            state       <= S_CMD;
          end else if (!ulpi_dir && phy_nopid_i) begin
            nopid_q     <= 1'b1;
            nxt_seen_q  <= 1'b0;
            ulpi_data_o <= NOPID_CMD;
            busy_o      <= 1'b1;
            state       <= S_NOPID;
          end
        end
        S_CMD, S_DATA: begin
          if (ulpi_dir) begin
            retry_q <= retry_q + RW'(1);
            ta_q    <= 1'b0;
            state   <= S_WAIT_DIR;
          end else if (state == S_CMD) begin
            ulpi_data_o <= ulpi_nxt ? req_q.data : req_q.addr;
            if (ulpi_nxt) state <= S_DATA;
          end else if (ulpi_nxt) begin
            ulpi_stp_o <= 1'b1;
            phy_done_o <= 1'b1;
            state      <= S_STOP;
          end else begin
            ulpi_data_o <= req_q.data;
          end
        end
        S_STOP: begin
          retry_q <= '0;
          busy_o  <= 1'b0;
          state   <= S_IDLE;
        end
        S_NOPID: begin
          if (ulpi_dir) begin
            ta_q  <= 1'b0;
            state <= S_WAIT_DIR;
          end else if (phy_stop_i) begin
            ulpi_stp_o <= 1'b1;
            state      <= S_NSTOP;
          end else begin
            nxt_seen_q <= nxt_seen_q | ulpi_nxt;
            if (!(nxt_seen_q || ulpi_nxt)) ulpi_data_o <= NOPID_CMD;
          end
        end
        S_NSTOP: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        S_WAIT_DIR: begin
          // Failed writes pulse done during the turnaround cycle, then leave next cycle.
          if (ta_q && (nopid_q || retry_q > RETRY_LIM)) begin
            retry_q <= '0;
            nopid_q <= 1'b0;
            busy_o  <= 1'b0;
            state   <= S_IDLE;
          end else if (ulpi_dir) begin
            ta_q <= 1'b0;
          end else if (!ta_q) begin
            ta_q <= 1'b1;
            if (!nopid_q && retry_q > RETRY_LIM) begin
              phy_done_o  <= 1'b1;
              phy_error_o <= 1'b1;
            end
          end else begin
            ulpi_data_o <= req_q.addr;
            state       <= S_CMD;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_tx_engine.sv
// Bench for ulpi_tx_engine: fixed vector table, hand-built corner sequences and random
// transactions expanded into per-cycle {stimulus, expected bus} records.
module tb_ulpi_tx_engine;
  localparam int         MAX_RETRY = 3;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ulpi_dir = 1'b0, ulpi_nxt = 1'b0;
  logic [7:0] ulpi_data_o;
  logic       ulpi_stp_o;
  logic       phy_write_i = 1'b0, phy_nopid_i = 1'b0, phy_stop_i = 1'b0;
  logic [7:0] phy_addr_i = 8'h00, phy_data_i = 8'h00;
  logic       phy_done_o, phy_error_o, busy_o;

  ulpi_tx_engine #(.MAX_RETRY(MAX_RETRY), .IDLE_BYTE(IDLE_BYTE)) dut (
    .clock(clock), .reset(reset), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
    .ulpi_data_o(ulpi_data_o), .ulpi_stp_o(ulpi_stp_o),
    .phy_write_i(phy_write_i), .phy_nopid_i(phy_nopid_i), .phy_stop_i(phy_stop_i),
    .phy_addr_i(phy_addr_i), .phy_data_i(phy_data_i),
    .phy_done_o(phy_done_o), .phy_error_o(phy_error_o), .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic dir, nxt, wr, nop, sp;
    logic [7:0] a, d;
    logic [7:0] ed;
    logic es, edn, eer, eb;
  } vec_t;

  vec_t q[$];
  vec_t tbl[12];
  int checks = 0, failures = 0, vec_no = 0;

  function automatic vec_t mk(logic dir, nxt, wr, nop, sp, logic [7:0] a, d, ed,
                              logic es, edn, eer, eb);
    vec_t v;
    v.dir = dir; v.nxt = nxt; v.wr = wr; v.nop = nop; v.sp = sp; v.a = a; v.d = d;
    v.ed = ed; v.es = es; v.edn = edn; v.eer = eer; v.eb = eb;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  // One expected cycle; junk toggles requests/addr/data that the block must ignore.
  task automatic pb(input logic dir, nxt, sp, input logic [7:0] ed,
                    input logic es, edn, eer, eb, input bit junk);
    vec_t v = mk(dir, nxt, 1'b0, 1'b0, sp, 8'h00, 8'h00, ed, es, edn, eer, eb);
    if (junk) begin
      v.wr = rb(); v.nop = rb(); v.a = 8'($urandom); v.d = 8'($urandom);
    end
    q.push_back(v);
  endtask

  // where: 0 = abort in CMD, 1 = abort in DATA, -1 = random per attempt
  task automatic add_write(input logic [7:0] a, d, input int cw, dw, nab, ablen, where,
                           input bit junk);
    q.push_back(mk(1'b0, 1'b0, 1'b1, junk ? rb() : 1'b0, 1'b0, a, d, a, 0, 0, 0, 1));
    for (int k = 1; k <= nab; k++) begin
      bit in_data = (where < 0) ? bit'($urandom % 2) : bit'(where);
      repeat (cw) pb(0, 0, junk ? rb() : 1'b0, a, 0, 0, 0, 1, junk);
      if (in_data) begin
        pb(0, 1, 0, d, 0, 0, 0, 1, junk);
        repeat (dw) pb(0, 0, junk ? rb() : 1'b0, d, 0, 0, 0, 1, junk);
      end
      pb(1, 0, 0, IDLE_BYTE, 0, 0, 0, 1, junk);
      repeat (ablen - 1) pb(1, junk ? rb() : 1'b0, 0, IDLE_BYTE, 0, 0, 0, 1, junk);
      if (k > MAX_RETRY) begin
        pb(0, 0, 0, IDLE_BYTE, 0, 1, 1, 1, junk);   // turnaround carries the error pulse
        pb(0, 0, 0, IDLE_BYTE, 0, 0, 0, 0, junk);
        return;
      end
      pb(0, 0, 0, IDLE_BYTE, 0, 0, 0, 1, junk);     // turnaround
      pb(0, 0, 0, a, 0, 0, 0, 1, junk);             // command reissued
    end
    repeat (cw) pb(0, 0, junk ? rb() : 1'b0, a, 0, 0, 0, 1, junk);
    pb(0, 1, 0, d, 0, 0, 0, 1, junk);
    repeat (dw) pb(0, 0, junk ? rb() : 1'b0, d, 0, 0, 0, 1, junk);
    pb(0, 1, 0, IDLE_BYTE, 1, 1, 0, 1, junk);
    pb(0, 0, 0, IDLE_BYTE, 0, 0, 0, 0, junk);
  endtask

  // mode: 0 = nxt then stop, 1 = stop before nxt, 2 = dir abort
  task automatic add_nopid(input int w, hold, mode, ablen, input bit junk);
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h40, 0, 0, 0, 1));
    repeat (w) pb(0, 0, 0, 8'h40, 0, 0, 0, 1, junk);
    if (mode == 2) begin
      if (rb()) pb(0, 1, 0, IDLE_BYTE, 0, 0, 0, 1, junk);
      pb(1, 0, 0, IDLE_BYTE, 0, 0, 0, 1, junk);
      repeat (ablen - 1) pb(1, 0, 0, IDLE_BYTE, 0, 0, 0, 1, junk);
      pb(0, 0, 0, IDLE_BYTE, 0, 0, 0, 1, junk);
      pb(0, 0, 0, IDLE_BYTE, 0, 0, 0, 0, junk);
      return;
    end
    if (mode == 0) begin
      pb(0, 1, 0, IDLE_BYTE, 0, 0, 0, 1, junk);
      repeat (hold) pb(0, junk ? rb() : 1'b0, 0, IDLE_BYTE, 0, 0, 0, 1, junk);
    end
    pb(0, 0, 1, IDLE_BYTE, 1, 0, 0, 1, junk);
    pb(0, 0, 0, IDLE_BYTE, 0, 0, 0, 0, junk);
  endtask

  task automatic add_idle();
    logic d = rb();
    q.push_back(mk(d, 1'b0, d ? rb() : 1'b0, d ? rb() : 1'b0, 1'b0,
                   8'($urandom), 8'($urandom), IDLE_BYTE, 0, 0, 0, 0));
  endtask

  task automatic chk(input string nm, input logic [7:0] got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic run_q();
    while (q.size() > 0) begin
      vec_t v = q.pop_front();
      ulpi_dir = v.dir; ulpi_nxt = v.nxt; phy_write_i = v.wr; phy_nopid_i = v.nop;
      phy_stop_i = v.sp; phy_addr_i = v.a; phy_data_i = v.d;
      @(posedge clock);
      #1;
      checks++;
      if ({ulpi_data_o, ulpi_stp_o, phy_done_o, phy_error_o, busy_o} !==
          {v.ed, v.es, v.edn, v.eer, v.eb}) begin
        failures++;
        $display("FAIL vec%0d got data=%h stp=%b done=%b err=%b busy=%b want data=%h stp=%b done=%b err=%b busy=%b",
                 vec_no, ulpi_data_o, ulpi_stp_o, phy_done_o, phy_error_o, busy_o,
                 v.ed, v.es, v.edn, v.eer, v.eb);
      end
      vec_no++;
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_data"}, ulpi_data_o, IDLE_BYTE);
    chk({nm, "_stp"},  {7'd0, ulpi_stp_o},  8'd0);
    chk({nm, "_done"}, {7'd0, phy_done_o},  8'd0);
    chk({nm, "_err"},  {7'd0, phy_error_o}, 8'd0);
    chk({nm, "_busy"}, {7'd0, busy_o},      8'd0);
  endtask

  initial begin
    // write 84/45: three cycles of 84 (nxt in the third), 45, then stp with done
    tbl[0]  = mk(0, 0, 1, 0, 0, 8'h84, 8'h45, 8'h84, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h84, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h84, 0, 0, 0, 1);
    tbl[3]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h45, 0, 0, 0, 1);
    tbl[4]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    // write+nopid together: write wins; a second write 84/54 while busy is ignored
    tbl[6]  = mk(0, 0, 1, 1, 0, 8'h81, 8'h12, 8'h81, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 0, 0, 8'h84, 8'h54, 8'h81, 0, 0, 0, 1);
    tbl[8]  = mk(0, 1, 1, 0, 0, 8'h84, 8'h54, 8'h12, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);

    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    foreach (tbl[i]) q.push_back(tbl[i]);
    run_q();

    add_write(8'h8A, 8'h00, 0, 0, 1, 3, 1, 0);          // dir 3 cycles in DATA, then reissue
    run_q();
    add_write(8'h8B, 8'h5A, 1, 0, 4, 1, 0, 0);          // four CMD aborts -> error
    run_q();
    add_nopid(1, 98, 0, 1, 0);                           // chirp, stop after ~100 cycles
    run_q();
    add_nopid(2, 0, 2, 2, 0);                            // dir during NOPID: no retry, no done
    run_q();

    // async reset in DATA must clear outputs before the next edge
    add_write(8'h84, 8'h33, 0, 0, 0, 1, 0, 0);
    q = q[0:1];
    run_q();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    add_write(8'h84, 8'h45, 1, 1, 0, 1, 0, 0);
    run_q();

    for (int t = 0; t < 60; t++) begin
      int kind = int'($urandom_range(0, 9));
      if (kind < 5)
        add_write(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                  int'($urandom_range(1, 4)), -1, 1);
      else if (kind < 8)
        add_nopid(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 1);
      else
        repeat (int'($urandom_range(1, 3))) add_idle();
      run_q();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
